// File: rtl/heu_win_rx.sv
// heu_win_rx -- receive side of the IPGU->HEU window handshake.
//
// Accepts WIN_DIM x WIN_DIM pixel windows streamed in row-major order and
// stores them in a two-deep window buffer. Each complete window is exposed
// to the histogram-equalization datapath through a registered random-access
// read port. The IPGU is back-pressured through rdyHeu, so a window that
// HEU still owns is never overwritten.
//
// Optional feature: define HEU_RX_MINMAX_EN to track per-window pixel
// min/max. Without it, winMin/winMax are tied to 0.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   vldIpgu/rdyHeu  window-level handshake (acceptance when both are high)
//   pixVld/pixData  pixel stream for the accepted window
//   winVld          a committed window is available at the read port
//   rdAddr/rdData   pixel read port, 1-cycle latency, out-of-range reads 0
//   winDone         HEU releases the current read window (1-cycle pulse)
//   winCnt          count of committed windows (wraps)
//   protoErr        sticky protocol-violation flag
//   winMin/winMax   stats of the current read window
module heu_win_rx #(
  parameter int PIX_W   = 8,
  parameter int WIN_DIM = 20,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vldIpgu,
  output logic              rdyHeu,
  input  logic              pixVld,
  input  logic [PIX_W-1:0]  pixData,
  output logic              winVld,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [PIX_W-1:0]  rdData,
  input  logic              winDone,
  output logic [15:0]       winCnt,
  output logic              protoErr,
  output logic [PIX_W-1:0]  winMin,
  output logic [PIX_W-1:0]  winMax
);

  localparam int WIN_PIX = WIN_DIM * WIN_DIM;
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(WIN_PIX - 1);
  // One extra bit so the range check also works when WIN_PIX == 2**ADDR_W.
  localparam logic [ADDR_W:0]   WIN_PIX_X = (ADDR_W + 1)'(WIN_PIX);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_COMMIT} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_wrPtr;
  logic               r_wrSel;
  logic               r_rdSel;
  logic [1:0]         r_full;
  logic               r_rdy;
  logic [15:0]        r_winCnt;
  logic               r_protoErr;
  logic [PIX_W-1:0]   r_rdData;
  logic [PIX_W-1:0]   r_mem [2][WIN_PIX];

  logic               w_winVld;
  logic               w_release;
  logic               w_commit;
  logic               w_wrEn;
  logic [1:0]         w_fullNxt;

  assign w_winVld  = r_full[r_rdSel];
  assign w_release = winDone & w_winVld;
  assign w_commit  = (r_state == S_COMMIT);
  assign w_wrEn    = (r_state == S_RECV) & pixVld;

  // Commit and release always target different buffers, so both can be
  // applied in the same cycle without conflict.
  always_comb begin
    w_fullNxt = r_full;
    if (w_commit)  w_fullNxt[r_wrSel] = 1'b1;
    if (w_release) w_fullNxt[r_rdSel] = 1'b0;
  end

`ifdef HEU_RX_MINMAX_EN
  logic [PIX_W-1:0] r_runMin, r_runMax;
  logic [PIX_W-1:0] r_minBuf [2];
  logic [PIX_W-1:0] r_maxBuf [2];
`endif

  // Write FSM plus buffer bookkeeping. rdyHeu is computed from the
  // next-cycle full flags so it is already valid in the IDLE cycle that
  // follows COMMIT or a release, giving a WIN_PIX+2 cycle window period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wrPtr    <= '0;
      r_wrSel    <= 1'b0;
      r_rdSel    <= 1'b0;
      r_full     <= 2'b00;
      r_rdy      <= 1'b0;
      r_winCnt   <= '0;
      r_protoErr <= 1'b0;
`ifdef HEU_RX_MINMAX_EN
      r_runMin    <= '1;
      r_runMax    <= '0;
      r_minBuf[0] <= '0;
      r_minBuf[1] <= '0;
      r_maxBuf[0] <= '0;
      r_maxBuf[1] <= '0;
`endif
    end else begin
      r_full <= w_fullNxt;
      if (w_release) r_rdSel <= ~r_rdSel;
      // Pixels outside RECV are dropped; releases with nothing held ignored.
      if ((winDone && !w_winVld) || (pixVld && r_state != S_RECV))
        r_protoErr <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (vldIpgu && r_rdy) begin
            r_state <= S_RECV;
            r_rdy   <= 1'b0;
            r_wrPtr <= '0;
`ifdef HEU_RX_MINMAX_EN
            r_runMin <= '1;
            r_runMax <= '0;
`endif
          end else begin
            r_rdy <= ~&w_fullNxt;
          end
        end
        S_RECV: begin
          if (pixVld) begin
            r_wrPtr <= r_wrPtr + ADDR_W'(1);
            if (r_wrPtr == LAST_PTR) r_state <= S_COMMIT;
`ifdef HEU_RX_MINMAX_EN
            if (pixData < r_runMin) r_runMin <= pixData;
            if (pixData > r_runMax) r_runMax <= pixData;
`endif
          end
        end
        S_COMMIT: begin
          r_wrSel  <= ~r_wrSel;
          r_winCnt <= r_winCnt + 16'd1;
          r_state  <= S_IDLE;
          r_rdy    <= ~&w_fullNxt;
`ifdef HEU_RX_MINMAX_EN
          r_minBuf[r_wrSel] <= r_runMin;
          r_maxBuf[r_wrSel] <= r_runMax;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Window storage: no reset needed, validity is tracked by r_full.
  always_ff @(posedge clk) begin
    if (w_wrEn) r_mem[r_wrSel][r_wrPtr] <= pixData;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                       r_rdData <= '0;
    else if ({1'b0, rdAddr} < WIN_PIX_X) r_rdData <= r_mem[r_rdSel][rdAddr];
    else                              r_rdData <= '0;
  end

  assign rdyHeu   = r_rdy;
  assign winVld   = w_winVld;
  assign rdData   = r_rdData;
  assign winCnt   = r_winCnt;
  assign protoErr = r_protoErr;

`ifdef HEU_RX_MINMAX_EN
  assign winMin = w_winVld ? r_minBuf[r_rdSel] : '0;
  assign winMax = w_winVld ? r_maxBuf[r_rdSel] : '0;
`else
  assign winMin = '0;
  assign winMax = '0;
`endif

endmodule

// File: tb/tb_heu_win_rx.sv
// Testbench for heu_win_rx. The reference model holds committed windows as
// one flat pixel queue (head window = first 400 entries); read responses are
// queued at issue time and checked by an independent monitor.
module tb_heu_win_rx;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 9;
  localparam int WP     = 400;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vldIpgu = 1'b0;
  logic              rdyHeu;
  logic              pixVld = 1'b0;
  logic [PIX_W-1:0]  pixData = '0;
  logic              winVld;
  logic [ADDR_W-1:0] rdAddr = '0;
  logic [PIX_W-1:0]  rdData;
  logic              winDone = 1'b0;
  logic [15:0]       winCnt;
  logic              protoErr;
  logic [PIX_W-1:0]  winMin, winMax;

  heu_win_rx #(.PIX_W(PIX_W), .WIN_DIM(20), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .vldIpgu(vldIpgu), .rdyHeu(rdyHeu),
    .pixVld(pixVld), .pixData(pixData), .winVld(winVld), .rdAddr(rdAddr),
    .rdData(rdData), .winDone(winDone), .winCnt(winCnt), .protoErr(protoErr),
    .winMin(winMin), .winMax(winMax)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model
  int unsigned mpix[$];
  int          m_cnt  = 0;
  bit          m_perr = 1'b0;

  // read scoreboard
  int unsigned exp_q[$];
  bit          rd_issue = 1'b0;
  bit          issued_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) issued_d <= rd_issue;

  always @(negedge clk) begin
    if (issued_d) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rdData_unexpected: got %0d expected none", rdData);
      end else begin
        chk("rdData", rdData, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int nwin();
    return mpix.size() / WP;
  endfunction

  function automatic int unsigned head_min();
    int unsigned m = 255;
    for (int i = 0; i < WP; i++) if (mpix[i] < m) m = mpix[i];
    return m;
  endfunction

  function automatic int unsigned head_max();
    int unsigned m = 0;
    for (int i = 0; i < WP; i++) if (mpix[i] > m) m = mpix[i];
    return m;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_winVld"}, winVld, (nwin() > 0));
    chk({tag, "_winCnt"}, winCnt, m_cnt & 16'hFFFF);
    chk({tag, "_protoErr"}, protoErr, m_perr);
`ifdef HEU_RX_MINMAX_EN
    chk({tag, "_winMin"}, winMin, nwin() > 0 ? head_min() : 0);
    chk({tag, "_winMax"}, winMax, nwin() > 0 ? head_max() : 0);
`else
    chk({tag, "_winMin"}, winMin, 0);
    chk({tag, "_winMax"}, winMax, 0);
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdyHeu"}, rdyHeu, 0);
    chk({tag, "_winVld"}, winVld, 0);
    chk({tag, "_rdData"}, rdData, 0);
    chk({tag, "_winCnt"}, winCnt, 0);
    chk({tag, "_protoErr"}, protoErr, 0);
    chk({tag, "_winMin"}, winMin, 0);
    chk({tag, "_winMax"}, winMax, 0);
  endtask

  task automatic model_reset();
    mpix.delete();
    m_cnt  = 0;
    m_perr = 1'b0;
  endtask

  // mode 0: addr%256, 1: random, 2: all 50 with pixel 7=3 and 399=250
  task automatic send_window(input int mode, input int gap_pct,
                             input bit done_at_commit, input int abort_at);
    int unsigned w[WP];
    int n = 0;
    int i = 0;
    for (int k = 0; k < WP; k++) begin
      if (mode == 0)      w[k] = k % 256;
      else if (mode == 1) w[k] = $urandom_range(255);
      else                w[k] = 50;
    end
    if (mode == 2) begin w[7] = 3; w[399] = 250; end

    vldIpgu = 1'b1;
    while (!rdyHeu && n < 100) begin step(); n++; end
    if (!rdyHeu) begin
      total++; bad++;
      $display("FAIL accept_timeout: got rdyHeu=0 expected 1 within 100 cycles");
      vldIpgu = 1'b0;
      return;
    end
    step();                       // acceptance edge
    vldIpgu = 1'b0;               // ignored during RECV
    chk("rdy_after_accept", rdyHeu, 0);

    while (i < WP) begin
      if (i == abort_at) begin
        pixVld = 1'b0;
        rst_n  = 1'b0;
        step();
        chk_reset("midreset");
        rst_n = 1'b1;
        model_reset();
        return;
      end
      if ($urandom_range(99) < gap_pct) begin
        pixVld = 1'b0;
      end else begin
        pixVld  = 1'b1;
        pixData = w[i][7:0];
        i++;
      end
      step();
      if (rdyHeu !== 1'b0) chk("rdy_during_recv", rdyHeu, 0);
    end
    pixVld = 1'b0;
    // last pixel taken; commit not yet visible
    chk("winCnt_pre_commit", winCnt, m_cnt & 16'hFFFF);
    chk("winVld_pre_commit", winVld, (nwin() > 0));
    if (done_at_commit) winDone = 1'b1;
    step();                       // COMMIT edge
    winDone = 1'b0;
    if (done_at_commit) begin
      if (nwin() > 0) for (int k = 0; k < WP; k++) void'(mpix.pop_front());
      else m_perr = 1'b1;
    end
    for (int k = 0; k < WP; k++) mpix.push_back(w[k]);
    m_cnt++;
    chk_state("commit");
    chk("rdy_after_commit", rdyHeu, (nwin() < 2));
  endtask

  task automatic release_win();
    winDone = 1'b1;
    step();
    winDone = 1'b0;
    if (nwin() > 0) for (int k = 0; k < WP; k++) void'(mpix.pop_front());
    else m_perr = 1'b1;
    chk_state("release");
    chk("rdy_after_release", rdyHeu, (nwin() < 2));
  endtask

  task automatic read_check(input int nrand);
    int unsigned a;
    for (int k = 0; k < 4 + nrand; k++) begin
      case (k)
        0: a = 399;
        1: a = 0;
        2: a = 400;
        3: a = 511;
        default: a = $urandom_range(511);
      endcase
      rdAddr   = a[ADDR_W-1:0];
      rd_issue = 1'b1;
      exp_q.push_back(a < WP ? mpix[a] : 0);
      step();
    end
    rd_issue = 1'b0;
    step();
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (3) step();
    chk_reset("reset");
    rst_n = 1'b1;
    step();
    chk("rdy_first_edge", rdyHeu, 1);

    // window 1: addr%256, contiguous
    send_window(0, 0, 1'b0, -1);
    rdAddr = 9'd399; rd_issue = 1'b1; exp_q.push_back(143);
    step(); rd_issue = 1'b0; step();
    read_check(8);

    // pixel in IDLE: dropped, flags protoErr, nothing else changes
    pixVld = 1'b1; pixData = 8'd77;
    step();
    pixVld = 1'b0;
    m_perr = 1'b1;
    chk_state("pix_idle");
    read_check(4);

    // reset clears protoErr, then winDone with no window
    rst_n = 1'b0; step(); chk_reset("reset2"); rst_n = 1'b1; model_reset();
    step();
    release_win();
    step();
    chk_state("perr_sticky");

    // two windows, no release: third must be held off
    send_window(0, 0, 1'b0, -1);
    send_window(1, 25, 1'b0, -1);
    vldIpgu = 1'b1;
    repeat (5) begin
      step();
      chk("rdy_both_full", rdyHeu, 0);
      chk("cnt_both_full", winCnt, m_cnt & 16'hFFFF);
    end
    release_win();
    vldIpgu = 1'b0;
    read_check(8);

    // release in the same cycle as the next window's commit
    send_window(1, 10, 1'b1, -1);
    read_check(8);

    // reset in the middle of a window, then a fresh window
    send_window(1, 0, 1'b0, 200);
    step();
    chk("rdy_after_midreset", rdyHeu, 1);
    send_window(2, 0, 1'b0, -1);
    read_check(4);

    // randomized traffic
    for (int r = 0; r < 4; r++) begin
      if (nwin() == 2) release_win();
      send_window(1, 20, 1'($urandom_range(1)), -1);
      read_check(6);
      if ($urandom_range(1) == 1 && nwin() > 0) begin
        release_win();
        if (nwin() > 0) read_check(4);
      end
    end

    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
